// File: rtl/decode_pipe.sv
// RV32 decode stage: register file read, immediate/control decode, load-use interlock, one-deep da_* register.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into operand reads.
module decode_pipe #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fd_valid,
    input  logic [XLEN-1:0] fd_pc,
    input  logic [31:0]     fd_instr,
    output logic            d_ready,
    input  logic            a_ready,
    input  logic            flush,
    input  logic            w_regfile,
    input  logic [RW-1:0]   sel_regfile,
    input  logic [XLEN-1:0] data_regfile,
    output logic            da_valid,
    output logic [XLEN-1:0] da_pc,
    output logic [XLEN-1:0] da_data1,
    output logic [XLEN-1:0] da_data2,
    output logic [XLEN-1:0] da_imm,
    output logic [XLEN-1:0] da_target_pc,
    output logic [RW-1:0]   da_read_sel1,
    output logic [RW-1:0]   da_read_sel2,
    output logic [RW-1:0]   da_write_sel,
    output logic [5:0]      da_alu_ctrl,
    output logic            da_is_wb,
    output logic            da_is_branch,
    output logic            da_is_jump,
    output logic            da_is_load,
    output logic            da_is_store,
    output logic            da_illegal
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    // RV64 shift immediates borrow funct7[0] as shamt[5]
    localparam logic [6:0] SHMASK   = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

    typedef struct packed {
        logic [XLEN-1:0] pc, data1, data2, imm, target_pc;
        logic [RW-1:0]   rs1, rs2, rd;
        logic [5:0]      alu_ctrl;
        logic            is_wb, is_branch, is_jump, is_load, is_store, illegal;
    } da_t;

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    da_t             da_q, da_d, dec;
    logic            da_valid_q, da_valid_d;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            legal, wb_class, uses_rs1, uses_rs2, hazard;

    function automatic logic [5:0] alu_of_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return 6'b000000;
            3'b001:  return 6'b000101;
            3'b010:  return 6'b001000;
            3'b011:  return 6'b001001;
            3'b100:  return 6'b000100;
            3'b101:  return 6'b000110;
            3'b110:  return 6'b000011;
            default: return 6'b000010;
        endcase
    endfunction

    assign opcode = fd_instr[6:0];
    assign funct3 = fd_instr[14:12];
    assign funct7 = fd_instr[31:25];
    assign rd     = fd_instr[7 +: RW];
    assign rs1    = fd_instr[15 +: RW];
    assign rs2    = fd_instr[20 +: RW];

    assign imm_i = XLEN'($signed(fd_instr[31:20]));
    assign imm_s = XLEN'($signed({fd_instr[31:25], fd_instr[11:7]}));
    assign imm_b = XLEN'($signed({fd_instr[31], fd_instr[7], fd_instr[30:25], fd_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({fd_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({fd_instr[31], fd_instr[19:12], fd_instr[20], fd_instr[30:21], 1'b0}));

    always_comb begin
        rdata1 = rf_q[rs1];
        rdata2 = rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (w_regfile && sel_regfile != '0 && sel_regfile == rs1) rdata1 = data_regfile;
        if (w_regfile && sel_regfile != '0 && sel_regfile == rs2) rdata2 = data_regfile;
`endif
    end

    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        wb_class  = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        dec.pc    = fd_pc;
        dec.rs1   = rs1;
        dec.rs2   = rs2;
        dec.rd    = rd;
        dec.data1 = rdata1;
        dec.data2 = rdata2;
        case (opcode)
            OP_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                wb_class = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal        = 1'b1;
                    dec.alu_ctrl = alu_of_f3(funct3);
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal        = 1'b1;
                    dec.alu_ctrl = (funct3 == 3'b000) ? 6'b000001 : 6'b000111;
                end
            end
            OP_I: begin
                uses_rs1     = 1'b1;
                wb_class     = 1'b1;
                dec.imm      = imm_i;
                dec.alu_ctrl = alu_of_f3(funct3);
                if (funct3 == 3'b001) begin
                    legal = (funct7 & SHMASK) == 7'b0000000;
                end else if (funct3 == 3'b101) begin
                    legal = ((funct7 & SHMASK) == 7'b0000000) || ((funct7 & SHMASK) == 7'b0100000);
                    if (funct7[5]) dec.alu_ctrl = 6'b000111;
                end else begin
                    legal = 1'b1;
                end
            end
            OP_LD: begin
                uses_rs1    = 1'b1;
                wb_class    = 1'b1;
                dec.imm     = imm_i;
                dec.is_load = 1'b1;
                legal       = funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111;
            end
            OP_ST: begin
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                dec.imm      = imm_s;
                dec.is_store = 1'b1;
                legal        = !funct3[2] && funct3 != 3'b011;
            end
            OP_BR: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                dec.alu_ctrl  = {3'b010, funct3};
                legal         = funct3[2:1] != 2'b01;
            end
            OP_LUI, OP_AUIPC: begin
                wb_class = 1'b1;
                dec.imm  = imm_u;
                legal    = 1'b1;
            end
            OP_JAL: begin
                wb_class    = 1'b1;
                dec.imm     = imm_j;
                dec.is_jump = 1'b1;
                legal       = 1'b1;
            end
            OP_JALR: begin
                uses_rs1    = 1'b1;
                wb_class    = 1'b1;
                dec.imm     = imm_i;
                dec.is_jump = 1'b1;
                legal       = funct3 == 3'b000;
            end
            default: ;
        endcase
        if (opcode == OP_BR || opcode == OP_JAL) dec.target_pc = fd_pc + dec.imm;
        dec.is_wb   = wb_class && legal && (rd != '0);
        dec.illegal = !legal;
        // an illegal word still travels down the pipe, but must not trigger any unit
        if (!legal) begin
            dec.alu_ctrl  = '0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
        end
    end

    assign hazard  = da_valid_q && da_q.is_load && (da_q.rd != '0) &&
                     ((uses_rs1 && rs1 == da_q.rd) || (uses_rs2 && rs2 == da_q.rd));
    assign d_ready = (!da_valid_q || a_ready) && !hazard && !flush;

    always_comb begin
        da_valid_d = da_valid_q;
        da_d       = da_q;
        if (flush) begin
            da_valid_d = 1'b0;
        end else if (fd_valid && d_ready) begin
            da_valid_d = 1'b1;
            da_d       = dec;
        end else if (!(da_valid_q && !a_ready)) begin
            da_valid_d = 1'b0;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (w_regfile && sel_regfile != '0) rf_d[sel_regfile] = data_regfile;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            da_valid_q <= 1'b0;
            da_q       <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            da_valid_q <= da_valid_d;
            da_q       <= da_d;
            rf_q       <= rf_d;
        end
    end

    assign da_valid     = da_valid_q;
    assign da_pc        = da_q.pc;
    assign da_data1     = da_q.data1;
    assign da_data2     = da_q.data2;
    assign da_imm       = da_q.imm;
    assign da_target_pc = da_q.target_pc;
    assign da_read_sel1 = da_q.rs1;
    assign da_read_sel2 = da_q.rs2;
    assign da_write_sel = da_q.rd;
    assign da_alu_ctrl  = da_q.alu_ctrl;
    assign da_is_wb     = da_q.is_wb;
    assign da_is_branch = da_q.is_branch;
    assign da_is_jump   = da_q.is_jump;
    assign da_is_load   = da_q.is_load;
    assign da_is_store  = da_q.is_store;
    assign da_illegal   = da_q.illegal;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, 32, datapath/PC width (32 or 64).
REQ-002 Parameter NREG, 32, architectural register count (power of two, ≤32); index width RW=log2(NREG).
REQ-003 clock  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 fd_valid  in  1  fetch presents valid fd_pc/fd_instr.
REQ-006 fd_pc  in  XLEN  PC of presented instruction.
REQ-007 fd_instr  in  32  RV32 instruction word.
REQ-008 d_ready  out  1  decode accepts this cycle (combinational).
REQ-009 a_ready  in  1  execute accepts da_* this cycle.
REQ-010 flush  in  1  kill held and presented instruction (taken branch).
REQ-011 w_regfile / sel_regfile / data_regfile  in  1 / RW / XLEN  writeback port.
REQ-012 da_valid  out  1  da_* hold a real instruction.
REQ-013 da_pc, da_data1, da_data2, da_imm, da_target_pc  out  XLEN each.
REQ-014 da_read_sel1, da_read_sel2, da_write_sel  out  RW each.
REQ-015 da_alu_ctrl  out  6  ALU operation code.
REQ-016 da_is_wb, da_is_branch, da_is_jump, da_is_load, da_is_store, da_illegal  out  1 each.

Function
REQ-017 Internal regfile NREG×XLEN; register 0 reads 0, writes to 0 ignored.
REQ-018 Transfer: fd_valid && d_ready loads all da_* at next edge, da_valid=1; one-cycle latency.
REQ-019 d_ready = (!da_valid || a_ready) && !hazard && !flush.
REQ-020 hazard = da_valid && da_is_load && da_write_sel≠0 && da_write_sel equals rs1 (if used) or rs2 (if used) of fd_instr.
REQ-021 On hazard with a_ready=1: da_valid←0 (bubble), fd_* held by fetch; no transfer.
REQ-022 Held: da_valid && !a_ready && !flush → all da_* unchanged.
REQ-023 Drain: a_ready && !(fd_valid && d_ready) → da_valid←0, other da_* don't-care.
REQ-024 flush=1 → da_valid←0 next edge regardless of a_ready/fd_valid; flush wins over all.
REQ-025 Immediates sign-extended to XLEN: I (0010011, 0000011, 1100111), S (0100011), B (1100011), U (0110111, 0010111, value<<12), J (1101111); others 0.
REQ-026 da_target_pc = fd_pc + imm modulo 2^XLEN for B and JAL; 0 otherwise.
REQ-027 alu_ctrl: R/I add 000000, sub 000001, and 000010, or 000011, xor 000100, sll 000101, srl 000110, sra 000111, slt 001000, sltu 001001; load/store/lui/auipc/jal/jalr 000000; beq 010000, bne 010001, blt 010100, bge 010101, bltu 010110, bgeu 010111.
REQ-028 is_wb for R, I-ALU, load, LUI, AUIPC, JAL, JALR, and forced 0 when rd=0.
REQ-029 Unrecognised opcode/funct → da_illegal=1, all other flags 0, still transferred.
REQ-030 Simultaneous writeback and read of the same register: see REQ-034/035.

Reset
REQ-031 reset=0 asynchronously clears all da_* to 0 including da_valid; regfile cleared to 0.
REQ-032 Reset mid-transfer drops the instruction; d_ready=1 in first cycle after release.

Configuration
REQ-033 Macro DECODE_WB_BYPASS_EN selects writeback-to-decode bypass.
REQ-034 Defined: read of sel_regfile while w_regfile=1 (sel≠0) returns data_regfile same cycle.
REQ-035 Undefined: such a read returns the old register value; writer must insert one-cycle gap.

Verification
REQ-036 Reset, then addi x1,x0,-5 (0xFFB00093) with fd_valid, a_ready=1 → next cycle da_valid=1, da_imm=0xFFFFFFFB, da_write_sel=1, da_is_wb=1, da_alu_ctrl=0.
REQ-037 lw x2,0(x1) then add x3,x2,x2 back-to-back → d_ready=0 one cycle, one bubble (da_valid=0), add issued next cycle.
REQ-038 beq at fd_pc=0x100 with imm=-8 → da_target_pc=0xF8, da_alu_ctrl=010000; flush next cycle → da_valid=0.
REQ-039 a_ready=0 for 3 cycles with da_valid=1 → da_* stable, d_ready=0; release → next instruction loaded.
REQ-040 Write x5=0xDEADBEEF while decoding add x6,x5,x0 → da_data1=0xDEADBEEF with DECODE_WB_BYPASS_EN, old value without.
REQ-041 XLEN=64 build, lui x7,0x80000 → da_imm=0xFFFFFFFF80000000.
